// File: rtl/nios_upc_jtag_ocimem_ctrl.sv
// Debug-RAM access controller: services JTAG reads/writes of the on-chip debug RAM
// through a one-entry pending slot and arbitrates a CPU Avalon-MM slave onto the same RAM.
module nios_upc_jtag_ocimem_ctrl #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   input  logic [3:0]        avs_byteenable,
   output logic [31:0]       avs_readdata,
   output logic              avs_waitrequest,
   output logic [31:0]       MonDReg,
   output logic              jtag_busy,
   output logic              jtag_overrun
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_JTAG_RD  = 3'd1,
      ST_JTAG_CAP = 3'd2,
      ST_CPU_RD   = 3'd3,
      ST_CPU_CAP  = 3'd4,
      ST_CPU_DONE = 3'd5
   } state_t;

   state_t              r_state;
   logic                r_slot_full;
   logic                r_slot_wr;
   logic [31:0]         r_slot_data;
   logic [ADDR_W-1:0]   r_mon_a;
   logic [31:0]         r_mon_d;
   logic [31:0]         r_avs_rdata;
   logic                r_waitreq;
   logic                r_overrun;
   logic [31:0]         r_q;
   logic [31:0]         r_mem [0:(2**ADDR_W)-1];

   logic                w_any_strobe;
   logic                w_multi_strobe;
   logic                w_jtag_state;
   logic                w_drop;
   logic                w_accept;
   logic                w_ram_we;
   logic                w_ram_re;
   logic [ADDR_W-1:0]   w_ram_addr;
   logic [31:0]         w_ram_wdata;
   logic [3:0]          w_ram_be;
   logic                w_unused_jdo;

   assign w_unused_jdo   = ^{jdo[37:35], jdo[2:0]};

   assign w_any_strobe   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
   assign w_multi_strobe = (take_action_ocimem_a & take_action_ocimem_b) |
                           (take_action_ocimem_a & take_no_action_ocimem_a) |
                           (take_action_ocimem_b & take_no_action_ocimem_a);
   assign w_jtag_state   = (r_state == ST_JTAG_RD) | (r_state == ST_JTAG_CAP);
   // A strobe is dropped whole (address load included) whenever JTAG work is already outstanding.
   assign w_drop         = w_any_strobe & (r_slot_full | w_jtag_state);
   assign w_accept       = w_any_strobe & ~w_drop;

   assign avs_readdata    = r_avs_rdata;
   assign avs_waitrequest = r_waitreq;
   assign MonDReg         = r_mon_d;
   assign jtag_overrun    = r_overrun;
   assign jtag_busy       = r_slot_full | w_jtag_state;

   // RAM port steering: pending JTAG work in IDLE has priority over the CPU request.
   always_comb begin
      w_ram_we    = 1'b0;
      w_ram_re    = 1'b0;
      w_ram_addr  = r_mon_a;
      w_ram_wdata = r_slot_data;
      w_ram_be    = 4'hF;
      if (r_state == ST_IDLE) begin
         if (r_slot_full) begin
            if (r_slot_wr) begin
               w_ram_we = ~reset;
            end else begin
               w_ram_re = 1'b1;
            end
         end else if (avs_read) begin
            w_ram_re   = 1'b1;
            w_ram_addr = avs_address;
         end else if (avs_write) begin
            w_ram_we    = ~reset;
            w_ram_addr  = avs_address;
            w_ram_wdata = avs_writedata;
            w_ram_be    = avs_byteenable;
         end else begin
            w_ram_we = 1'b0;
         end
      end else begin
         w_ram_re = 1'b0;
      end
   end

   // Debug RAM: byte-lane writes, registered read data held until the next read.
   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (w_ram_be[b]) begin
               r_mem[w_ram_addr][b*8 +: 8] <= w_ram_wdata[b*8 +: 8];
            end
         end
      end
      if (w_ram_re) begin
         r_q <= r_mem[w_ram_addr];
      end
   end

   // Access FSM together with the JTAG strobe decode into the pending slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_slot_full <= 1'b0;
         r_slot_wr   <= 1'b0;
         r_slot_data <= 32'h0000_0000;
         r_mon_a     <= {ADDR_W{1'b0}};
         r_mon_d     <= 32'h0000_0000;
         r_avs_rdata <= 32'h0000_0000;
         r_waitreq   <= 1'b1;
         r_overrun   <= 1'b0;
      end else begin
         r_waitreq <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (r_slot_full) begin
                  r_slot_full <= 1'b0;
                  if (r_slot_wr) begin
                     r_mon_a <= r_mon_a + {{(ADDR_W-1){1'b0}}, 1'b1};
                  end else begin
                     r_state <= ST_JTAG_RD;
                  end
               end else if (avs_read) begin
                  r_state <= ST_CPU_RD;
               end else if (avs_write) begin
                  r_state   <= ST_CPU_DONE;
                  r_waitreq <= 1'b0;
               end
            end
            ST_JTAG_RD:  r_state <= ST_JTAG_CAP;
            ST_JTAG_CAP: begin
               r_mon_d <= r_q;
               r_mon_a <= r_mon_a + {{(ADDR_W-1){1'b0}}, 1'b1};
               r_state <= ST_IDLE;
            end
            ST_CPU_RD:   r_state <= ST_CPU_CAP;
            ST_CPU_CAP: begin
               r_avs_rdata <= r_q;
               r_waitreq   <= 1'b0;
               r_state     <= ST_CPU_DONE;
            end
            ST_CPU_DONE: r_state <= ST_IDLE;
            default:     r_state <= ST_IDLE;
         endcase

         // Slot set and FSM clear never coincide: acceptance needs an empty slot.
         if (w_drop) begin
            r_overrun <= 1'b1;
         end else if (w_accept) begin
            if (w_multi_strobe) begin
               r_overrun <= 1'b1;
            end
            if (take_action_ocimem_b) begin
               r_slot_full <= 1'b1;
               r_slot_wr   <= 1'b1;
               r_slot_data <= jdo[34:3];
            end else if (take_action_ocimem_a) begin
               r_mon_a <= jdo[26 +: ADDR_W];
               if (jdo[25]) begin
                  r_slot_full <= 1'b1;
                  r_slot_wr   <= 1'b0;
               end
            end else begin
               r_slot_full <= 1'b1;
               r_slot_wr   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_nios_upc_jtag_ocimem_ctrl.sv
// Directed plus randomized bench for nios_upc_jtag_ocimem_ctrl against a transaction-level
// model of the debug RAM, MonAReg and MonDReg.
module tb_nios_upc_jtag_ocimem_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [37:0] jdo = 38'd0;
   logic        t_a = 1'b0, t_b = 1'b0, t_na = 1'b0;
   logic [7:0]  avs_address = 8'd0;
   logic        avs_read = 1'b0, avs_write = 1'b0;
   logic [31:0] avs_writedata = 32'd0;
   logic [3:0]  avs_byteenable = 4'd0;
   logic [31:0] avs_readdata, MonDReg;
   logic        avs_waitrequest, jtag_busy, jtag_overrun;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_mem [256];
   logic [7:0]  m_mon_a = 8'd0;
   logic [31:0] m_mon_d = 32'd0;

   nios_upc_jtag_ocimem_ctrl #(.ADDR_W(8)) dut (
      .clk(clk), .reset(reset), .jdo(jdo),
      .take_action_ocimem_a(t_a), .take_action_ocimem_b(t_b), .take_no_action_ocimem_a(t_na),
      .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
      .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
      .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
      .MonDReg(MonDReg), .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [37:0] rnd_jdo();
      logic [37:0] j;
      j = {6'($urandom), 32'($urandom)};
      return j;
   endfunction

   task automatic strobe(input int kind, input logic [37:0] j);
      jdo  = j;
      t_a  = (kind == 0);
      t_b  = (kind == 1);
      t_na = (kind == 2);
      tick();
      t_a = 1'b0; t_b = 1'b0; t_na = 1'b0;
   endtask

   task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
      avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
      tick();
      chk("cpu_wr_waitreq", avs_waitrequest, 1'b0);
      avs_write = 1'b0;
      m_mem[a] = merge(m_mem[a], d, be);
      tick();
   endtask

   task automatic cpu_read(input logic [7:0] a);
      avs_address = a; avs_read = 1'b1;
      tick(); tick();
      chk("cpu_rd_wait_c2", avs_waitrequest, 1'b1);
      tick();
      chk("cpu_rd_wait_c3", avs_waitrequest, 1'b0);
      chk("cpu_rd_data", avs_readdata, m_mem[a]);
      avs_read = 1'b0;
      tick();
      chk("cpu_rd_wait_c4", avs_waitrequest, 1'b1);
   endtask

   task automatic jtag_a(input logic [7:0] a, input logic rd);
      logic [37:0] j;
      j = rnd_jdo();
      j[33:26] = a;
      j[25] = rd;
      strobe(0, j);
      m_mon_a = a;
      if (rd) begin
         m_mon_d = m_mem[m_mon_a];
         m_mon_a = m_mon_a + 8'd1;
      end
      repeat (5) tick();
      chk("jtag_a_mondreg", MonDReg, m_mon_d);
      chk("jtag_a_busy", jtag_busy, 1'b0);
   endtask

   task automatic jtag_b(input logic [31:0] d);
      logic [37:0] j;
      j = rnd_jdo();
      j[34:3] = d;
      strobe(1, j);
      m_mem[m_mon_a] = d;
      m_mon_a = m_mon_a + 8'd1;
      repeat (3) tick();
   endtask

   task automatic jtag_rd();
      strobe(2, rnd_jdo());
      m_mon_d = m_mem[m_mon_a];
      m_mon_a = m_mon_a + 8'd1;
      repeat (5) tick();
      chk("jtag_rd_mondreg", MonDReg, m_mon_d);
   endtask

   initial begin
      logic [37:0] j;
      logic [31:0] old_d;
      logic [7:0]  x;

      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("rst_waitreq", avs_waitrequest, 1'b1);
      chk("rst_mondreg", MonDReg, 32'h0);
      chk("rst_readdata", avs_readdata, 32'h0);
      chk("rst_busy", jtag_busy, 1'b0);
      chk("rst_overrun", jtag_overrun, 1'b0);
      repeat (3) tick();
      chk("idle_waitreq", avs_waitrequest, 1'b1);

      for (int a = 0; a < 256; a++) begin
         m_mem[a] = 32'h0;
         cpu_write(8'(a), $urandom, 4'hF);
      end

      // Address load near the top, then three writes that wrap MonAReg.
      jtag_a(8'hFE, 1'b0);
      repeat (3) tick();
      jtag_b(32'h1111_1111); repeat (4) tick();
      jtag_b(32'h2222_2222); repeat (4) tick();
      jtag_b(32'h3333_3333);
      cpu_read(8'hFE);
      cpu_read(8'hFF);
      cpu_read(8'h00);
      chk("wrap_ff", m_mem[8'hFF], 32'h2222_2222);
      jtag_rd();

      // Partial byte write then JTAG load+read with exact latency.
      cpu_write(8'd5, 32'h0, 4'hF);
      cpu_write(8'd5, 32'hDEAD_BEEF, 4'b0011);
      cpu_write(8'd6, 32'hCAFE_F00D, 4'b0000);
      cpu_read(8'd6);
      old_d = m_mon_d;
      j = rnd_jdo(); j[33:26] = 8'd5; j[25] = 1'b1;
      strobe(0, j);
      chk("rd_busy_t1", jtag_busy, 1'b1);
      tick(); tick();
      chk("rd_old_t3", MonDReg, old_d);
      chk("rd_busy_t3", jtag_busy, 1'b1);
      tick();
      chk("rd_beef_t4", MonDReg, 32'h0000_BEEF);
      chk("rd_busy_t4", jtag_busy, 1'b0);
      m_mon_d = 32'h0000_BEEF;
      m_mon_a = 8'd6;

      // CPU read and JTAG read strobe in the same cycle.
      x = 8'd200;
      old_d = m_mon_d;
      avs_address = x; avs_read = 1'b1;
      jdo = rnd_jdo(); t_na = 1'b1;
      tick();
      t_na = 1'b0;
      chk("both_busy_c1", jtag_busy, 1'b1);
      tick(); tick();
      chk("both_wait_c3", avs_waitrequest, 1'b0);
      chk("both_data_c3", avs_readdata, m_mem[x]);
      avs_read = 1'b0;
      repeat (3) tick();
      chk("both_mond_c6", MonDReg, old_d);
      tick(); tick();
      m_mon_d = m_mem[m_mon_a];
      m_mon_a = m_mon_a + 8'd1;
      chk("both_mond_c8", MonDReg, m_mon_d);
      chk("both_overrun", jtag_overrun, 1'b0);

      // Randomized transaction mix.
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 4))
            0: cpu_write(8'($urandom), $urandom, 4'($urandom));
            1: cpu_read(8'($urandom));
            2: jtag_a(8'($urandom), 1'($urandom));
            3: jtag_b($urandom);
            default: jtag_rd();
         endcase
      end
      chk("rand_overrun", jtag_overrun, 1'b0);

      // Two read strobes one cycle apart: second is dropped.
      strobe(2, rnd_jdo());
      strobe(2, rnd_jdo());
      chk("drop_overrun", jtag_overrun, 1'b1);
      m_mon_d = m_mem[m_mon_a];
      m_mon_a = m_mon_a + 8'd1;
      repeat (4) tick();
      chk("drop_mondreg", MonDReg, m_mon_d);
      jtag_rd();
      chk("drop_sticky", jtag_overrun, 1'b1);

      // Dropped address load while busy must not move MonAReg.
      strobe(2, rnd_jdo());
      j = rnd_jdo(); j[33:26] = m_mon_a + 8'd77; j[25] = 1'b0;
      strobe(0, j);
      m_mon_d = m_mem[m_mon_a];
      m_mon_a = m_mon_a + 8'd1;
      repeat (4) tick();
      chk("drop_load_mond", MonDReg, m_mon_d);
      jtag_rd();

      // Simultaneous write and read strobes: write wins.
      j = rnd_jdo(); j[34:3] = 32'h5A5A_C3C3;
      jdo = j; t_b = 1'b1; t_na = 1'b1;
      tick();
      t_b = 1'b0; t_na = 1'b0;
      x = m_mon_a;
      m_mem[m_mon_a] = 32'h5A5A_C3C3;
      m_mon_a = m_mon_a + 8'd1;
      repeat (3) tick();
      cpu_read(x);
      jtag_rd();

      // Reset while in CPU_CAP.
      cpu_write(8'd9, 32'hA5A5_5A5A, 4'hF);
      avs_address = 8'd9; avs_read = 1'b1;
      tick(); tick();
      reset = 1'b1;
      tick();
      chk("rstcap_waitreq", avs_waitrequest, 1'b1);
      chk("rstcap_readdata", avs_readdata, 32'h0);
      chk("rstcap_overrun", jtag_overrun, 1'b0);
      chk("rstcap_mondreg", MonDReg, 32'h0);
      reset = 1'b0; avs_read = 1'b0;
      m_mon_a = 8'd0; m_mon_d = 32'h0;
      tick();
      cpu_read(8'd9);
      jtag_rd();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
